// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, then raises ready.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          state_dbg,
  output logic [AW-1:0] clr_ptr,
  output logic          ready
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        ptr_d   = ptr_q + 1'b1;
        ready_d = 1'b0;
        if (ptr_q == LAST_ADDR) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN:     ready_d = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign state_dbg = state_q;
  assign clr_ptr   = ptr_q;
  assign ready     = ready_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a busy scoreboard and optional
// same-cycle forwarding; storage is zeroed by a post-reset walk, not by reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic [NRD*AW-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]     rd_busy,
  input  logic               wr0_en,
  input  logic [AW-1:0]      wr0_addr,
  input  logic [WIDTH-1:0]   wr0_data,
  input  logic               wr1_en,
  input  logic [AW-1:0]      wr1_addr,
  input  logic [WIDTH-1:0]   wr1_data,
  input  logic               issue_en,
  input  logic [AW-1:0]      issue_addr
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             seq_state;
  logic [AW-1:0]    clr_ptr;
  logic             clearing;
  logic             wr0_ok, wr1_ok, iss_ok;

  rf_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .state_dbg (seq_state),
    .clr_ptr   (clr_ptr),
    .ready     (ready)
  );

  assign clearing = (seq_state == CLEAR);
  // Address 0 is hardwired to zero, so anything aimed at it is dropped here.
  assign wr0_ok = ready && wr0_en   && (wr0_addr   != '0);
  assign wr1_ok = ready && wr1_en   && (wr1_addr   != '0);
  assign iss_ok = ready && issue_en && (issue_addr != '0);

  // wr1 is assigned last so it wins an address collision with wr0.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_ptr] <= '0;
    end else if (reset) begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  // A same-cycle issue is a newer producer than the write, so its set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (wr0_ok) busy[wr0_addr]   <= 1'b0;
      if (wr1_ok) busy[wr1_addr]   <= 1'b0;
      if (iss_ok) busy[issue_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             b;
    logic             hit0, hit1, hit_iss;

    assign a = rd_addr[k*AW +: AW];

    always_comb begin
      hit0    = wr0_ok && (wr0_addr   == a);
      hit1    = wr1_ok && (wr1_addr   == a);
      hit_iss = iss_ok && (issue_addr == a);
      d = mem[a];
      b = busy[a];
      if (BYPASS != 0) begin
        if (hit1)      d = wr1_data;
        else if (hit0) d = wr0_data;
        if ((hit0 || hit1) && !hit_iss) b = 1'b0;
      end
      if (!ready || a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*WIDTH +: WIDTH] = d;
    assign rd_busy[k] = b;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear timing, write/read, collisions, zero register,
// scoreboard and mid-run reset, with a forwarding and a non-forwarding instance.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        ready, ready_nb;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wr0_en, wr1_en, issue_en;
  logic [4:0]  wr0_addr, wr1_addr, issue_addr;
  logic [31:0] wr0_data, wr1_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        ie;  logic [4:0] ia;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] d0;  logic b0; logic [31:0] d1; logic b1;
    logic [31:0] nd0; logic nb0;
  } vec_t;
  vec_t vecs [16];

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ready(ready_nb),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
    wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
    issue_en = v.ie; issue_addr = v.ia;
    rd_addr = {v.ra1, v.ra0};
  endtask

  // Counts edges after reset release until ready; expects exactly 32.
  task automatic wait_ready(input string nm);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        chk({nm, "_clear_rd_data"}, rd_data[31:0], 32'h0);
        chk({nm, "_clear_rd_busy"}, {30'h0, rd_busy}, 32'h0);
      end
      if (ready) break;
    end
    chk({nm, "_ready_edges"}, n, 32);
    chk({nm, "_ready_nb"}, {31'h0, ready_nb}, 32'h1);
  endtask

  initial begin
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 31, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 31, 32'h1111, 1, 31, 32'h2222, 0, 0, 31, 5, 32'h2222, 0, 32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 31, 1, 32'h2222, 0, 0, 0, 32'h2222, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 0, 32'h2222, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 0, 1, 32'hDEADBEEF, 0, 0, 1};
    vecs[8]  = '{1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 6, 32'h77, 1, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 31, 32'h77, 1, 32'h2222, 0, 32'h77, 1};
    vecs[10] = '{1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 7, 32'h78, 0, 32'h78, 0, 32'h77, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 31, 32'h78, 0, 32'h2222, 0, 32'h78, 0};
    vecs[12] = '{1, 11, 32'h1234, 1, 10, 32'hABCD, 1, 9, 10, 11, 32'hABCD, 0, 32'h1234, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 10, 0, 1, 32'hABCD, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 11, 32'h99, 0, 32'h1234, 0, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h99, 0, 32'h78, 0, 32'h99, 0};

    // Held reset: stays in CLEAR with ready low.
    idle();
    rd_addr = '0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("reset_ready", {31'h0, ready}, 32'h0);
    end

    // Release with a write and issue to address 2 held throughout CLEAR; both must be ignored.
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hBAD0BAD0;
    issue_en = 1'b1; issue_addr = 5'd2;
    rd_addr = {5'd2, 5'd2};
    reset = 1'b1;
    wait_ready("init");
    @(negedge clk);
    idle();

    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {5'(31 - a), 5'(a)};
      #2;
      chk($sformatf("clear_rd0_a%0d", a), rd_data[31:0], 32'h0);
      chk($sformatf("clear_rd1_a%0d", 31 - a), rd_data[63:32], 32'h0);
      chk($sformatf("clear_busy_a%0d", a), {30'h0, rd_busy}, 32'h0);
    end

    // Table-driven vectors, checked just before each rising edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      chk($sformatf("v%0d_d0", i), rd_data[31:0], vecs[i].d0);
      chk($sformatf("v%0d_b0", i), {31'h0, rd_busy[0]}, {31'h0, vecs[i].b0});
      chk($sformatf("v%0d_d1", i), rd_data[63:32], vecs[i].d1);
      chk($sformatf("v%0d_b1", i), {31'h0, rd_busy[1]}, {31'h0, vecs[i].b1});
      chk($sformatf("v%0d_nb_d0", i), rd_data_nb[31:0], vecs[i].nd0);
      chk($sformatf("v%0d_nb_b0", i), {31'h0, rd_busy_nb[0]}, {31'h0, vecs[i].nb0});
    end

    // Mid-run reset: write 3, mark 12 busy, then a one-cycle reset pulse.
    @(negedge clk);
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5;
    issue_en = 1'b1; issue_addr = 5'd12;
    rd_addr = {5'd12, 5'd3};
    @(negedge clk);
    idle();
    #2;
    chk("mid_pre_d3", rd_data[31:0], 32'hA5);
    chk("mid_pre_busy12", {31'h0, rd_busy[1]}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_ready_low", {31'h0, ready}, 32'h0);
    chk("mid_busy_gated", {30'h0, rd_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready("mid");
    @(negedge clk);
    rd_addr = {5'd12, 5'd3};
    #2;
    chk("mid_post_d3", rd_data[31:0], 32'h0);
    chk("mid_post_nb_d3", rd_data_nb[31:0], 32'h0);
    chk("mid_post_busy12", {31'h0, rd_busy[1]}, 32'h0);
    chk("mid_post_nb_busy12", {31'h0, rd_busy_nb[1]}, 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
